// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRKWAIT
  } rx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Rounded clocks per oversample tick.
  function automatic int calc_divider(input int clk_freq, input int baud_rate,
                                      input int oversample_rate);
    int den;
    den = baud_rate * oversample_rate;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Input conditioning for the RX pin: 2-FF synchroniser followed by a
// 3-sample majority vote that advances only on oversample ticks.
module uart_rx_filter
  import uart_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic rxd_i,
  output logic rx_f_o
);

  logic [1:0] sync_q, sync_d;
  logic [2:0] samp_q, samp_d;

  always_comb begin
    sync_d = {sync_q[0], rxd_i};
    samp_d = samp_q;
    if (tick_i) begin
      samp_d = {samp_q[1:0], sync_q[1]};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= {2{UART_IDLE_LEVEL}};
      samp_q <= {3{UART_IDLE_LEVEL}};
    end else begin
      sync_q <= sync_d;
      samp_q <= samp_d;
    end
  end

  assign rx_f_o = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: oversampled, majority-filtered, LSB-first deserialiser with
// framing-error and break detection. Parity checking is built in when the
// UART_RX_PARITY_EN macro is defined.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int ClkFreq        = 100000000,
  parameter int BaudRate       = 115200,
  parameter int OversampleRate = 16,
  parameter int DataBits       = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter int ParityOdd      = 0
`endif
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       uart_rxd_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       frame_error_o,
  output logic       break_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error_o,
`endif
  output logic       busy_o
);

  localparam int Divider    = calc_divider(ClkFreq, BaudRate, OversampleRate);
  localparam int TickW      = (Divider > 1) ? $clog2(Divider) : 1;
  localparam int ScntW      = $clog2(OversampleRate);
  localparam int MidSample  = OversampleRate / 2 - 1;
  localparam int LastSample = OversampleRate - 1;

  if (Divider < 1) begin : g_bad_divider
    $error("uart_rx_core: clock too slow for BaudRate*OversampleRate");
  end
  if ((OversampleRate < 8) || (OversampleRate % 2 != 0)) begin : g_bad_oversample
    $error("uart_rx_core: OversampleRate must be even and >= 8");
  end
  if ((DataBits < 5) || (DataBits > 8)) begin : g_bad_databits
    $error("uart_rx_core: DataBits must be 5..8");
  end

  logic             tick;
  logic             start_edge;
  logic             rx_f;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             rx_f_prev_q, rx_f_prev_d;
  rx_state_t        state_q, state_d;
  logic [ScntW-1:0] scnt_q, scnt_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             brk_q, brk_d;
`ifdef UART_RX_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             perr_q, perr_d;
  logic             parity_ok;
  assign parity_ok = ((^shift_q) ^ par_bit_q) == ParityOdd[0];
`endif

  uart_rx_filter u_filter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_i  (tick),
    .rxd_i   (uart_rxd_i),
    .rx_f_o  (rx_f)
  );

  assign tick       = (tick_cnt_q == TickW'(Divider - 1));
  assign start_edge = (state_q == IDLE) && rx_f_prev_q && !rx_f;

  // Restarting the divider on the start edge aligns sampling to the edge.
  always_comb begin
    tick_cnt_d  = tick_cnt_q + 1'b1;
    if (start_edge || tick) begin
      tick_cnt_d = '0;
    end
    rx_f_prev_d = rx_f;
  end

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    brk_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          scnt_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (scnt_q == ScntW'(MidSample)) begin
            if (!rx_f) begin
              state_d  = DATA;
              scnt_d   = '0;
              bitcnt_d = '0;
              shift_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt_q == ScntW'(LastSample)) begin
            scnt_d   = '0;
            shift_d  = {rx_f, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 1'b1;
            if (bitcnt_q == 3'(DataBits - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (scnt_q == ScntW'(LastSample)) begin
            scnt_d    = '0;
            par_bit_d = rx_f;
            state_d   = STOP;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (scnt_q == ScntW'(LastSample)) begin
            if (rx_f) begin
              // Leaving at mid-stop lets a back-to-back start bit be caught.
              state_d = IDLE;
`ifdef UART_RX_PARITY_EN
              if (parity_ok) begin
                data_d  = shift_q >> (8 - DataBits);
                valid_d = 1'b1;
              end else begin
                perr_d = 1'b1;
              end
`else
              data_d  = shift_q >> (8 - DataBits);
              valid_d = 1'b1;
`endif
            end else begin
              state_d = BRKWAIT;
              if (shift_q == '0) begin
                brk_d = 1'b1;
              end else begin
                ferr_d = 1'b1;
              end
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
      end
      BRKWAIT: begin
        if (rx_f) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tick_cnt_q  <= '0;
      rx_f_prev_q <= UART_IDLE_LEVEL;
      state_q     <= IDLE;
      scnt_q      <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      brk_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q   <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      rx_f_prev_q <= rx_f_prev_d;
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      brk_q       <= brk_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q   <= par_bit_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign data_o        = data_q;
  assign data_valid_o  = valid_q;
  assign frame_error_o = ferr_q;
  assign break_o       = brk_q;
  assign busy_o        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_error_o = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit (divider 1).
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_core;

  localparam int BitClks = 16;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       rxd;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       frame_error_o;
  logic       break_o;
  logic       busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_error_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int brk_cnt   = 0;
  int perr_cnt  = 0;
  int v0, f0, b0, p0;
  logic       busy_mid;
  logic [7:0] exp_q[$];

  uart_rx_core #(
    .ClkFreq        (1843200),
    .BaudRate       (115200),
    .OversampleRate (16),
    .DataBits       (8)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .uart_rxd_i     (rxd),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
    .frame_error_o  (frame_error_o),
    .break_o        (break_o),
`ifdef UART_RX_PARITY_EN
    .parity_error_o (parity_error_o),
`endif
    .busy_o         (busy_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: strobes sampled on the falling edge
  always @(negedge clk) begin
    if (!reset_i) begin
      if (data_valid_o) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(data_valid_o), 32'd0);
        end else begin
          check("rx_byte", 32'(data_o), 32'(exp_q.pop_front()));
        end
      end
      if (frame_error_o) ferr_cnt++;
      if (break_o) brk_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_error_o) perr_cnt++;
`endif
    end
  end

  // driver tasks
  task automatic drive_bits(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bits(1'b0, BitClks);
    for (int i = 0; i < 8; i++) begin
      drive_bits(d[i], BitClks / 2);
      if (i == 4) busy_mid = busy_o;
      drive_bits(d[i], BitClks / 2);
    end
`ifdef UART_RX_PARITY_EN
    drive_bits(^d, BitClks);
`endif
    drive_bits(stop, BitClks);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic pbit);
    drive_bits(1'b0, BitClks);
    for (int i = 0; i < 8; i++) drive_bits(d[i], BitClks);
    drive_bits(pbit, BitClks);
    drive_bits(1'b1, BitClks);
  endtask
`endif

  task automatic snap();
    v0 = valid_cnt;
    f0 = ferr_cnt;
    b0 = brk_cnt;
    p0 = perr_cnt;
  endtask

  initial begin
    reset_i  = 1'b1;
    rxd      = 1'b1;
    busy_mid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_data", 32'(data_o), 32'h00);
    check("rst_valid", 32'(data_valid_o), 32'd0);
    check("rst_ferr", 32'(frame_error_o), 32'd0);
    check("rst_brk", 32'(break_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    reset_i = 1'b0;
    drive_bits(1'b1, 2 * BitClks);

    // 0x55 good frame
    snap();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    drive_bits(1'b1, 2 * BitClks);
    check("t1_busy_mid", 32'(busy_mid), 32'd1);
    check("t1_valid_cnt", valid_cnt - v0, 1);
    check("t1_ferr_cnt", ferr_cnt - f0, 0);
    check("t1_brk_cnt", brk_cnt - b0, 0);
    check("t1_data", 32'(data_o), 32'h55);
    check("t1_busy_after", 32'(busy_o), 32'd0);
    check("t1_exp_empty", exp_q.size(), 0);

    // 3-clock glitch on idle line
    snap();
    drive_bits(1'b0, 3);
    drive_bits(1'b1, 2 * BitClks);
    check("t2_valid_cnt", valid_cnt - v0, 0);
    check("t2_ferr_cnt", ferr_cnt - f0, 0);
    check("t2_brk_cnt", brk_cnt - b0, 0);
    check("t2_data", 32'(data_o), 32'h55);
    check("t2_busy", 32'(busy_o), 32'd0);

    // 0xA5 with stop bit low
    snap();
    send_frame(8'hA5, 1'b0);
    drive_bits(1'b1, 2 * BitClks);
    check("t3_ferr_cnt", ferr_cnt - f0, 1);
    check("t3_valid_cnt", valid_cnt - v0, 0);
    check("t3_brk_cnt", brk_cnt - b0, 0);
    check("t3_data", 32'(data_o), 32'h55);

    // line break: 20 bit times low
    snap();
    drive_bits(1'b0, 20 * BitClks);
    check("t4_busy_held", 32'(busy_o), 32'd1);
    drive_bits(1'b1, 2 * BitClks);
    check("t4_brk_cnt", brk_cnt - b0, 1);
    check("t4_ferr_cnt", ferr_cnt - f0, 0);
    check("t4_valid_cnt", valid_cnt - v0, 0);
    check("t4_busy_after", 32'(busy_o), 32'd0);

    // back-to-back 0x00 then 0xFF, no idle gap
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_bits(1'b1, 2 * BitClks);
    check("t5_valid_cnt", valid_cnt - v0, 2);
    check("t5_exp_empty", exp_q.size(), 0);
    check("t5_data", 32'(data_o), 32'hFF);
    check("t5_err_cnt", (ferr_cnt - f0) + (brk_cnt - b0), 0);

    // reset in the middle of data bit 3 of 0x3C
    snap();
    drive_bits(1'b0, BitClks);
    for (int i = 0; i < 3; i++) drive_bits(logic'(8'h3C >> i), BitClks);
    drive_bits(1'b1, BitClks / 2);
    reset_i = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_data", 32'(data_o), 32'h00);
    reset_i = 1'b0;
    drive_bits(1'b1, 3 * BitClks);
    check("t6_abort_valid", valid_cnt - v0, 0);
    check("t6_abort_busy", 32'(busy_o), 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    drive_bits(1'b1, 2 * BitClks);
    check("t6_valid_cnt", valid_cnt - v0, 1);
    check("t6_data", 32'(data_o), 32'h81);
    check("t6_exp_empty", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones; even parity bit should be 1, send 0
    snap();
    send_frame_par(8'h07, 1'b0);
    drive_bits(1'b1, 2 * BitClks);
    check("t7_perr_cnt", perr_cnt - p0, 1);
    check("t7_valid_cnt", valid_cnt - v0, 0);
    check("t7_data", 32'(data_o), 32'h81);
`endif

    check("final_ferr_total", ferr_cnt, 1);
    check("final_brk_total", brk_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
